mux_rr_pipe: RTL
================

MUX_RR_PIPE -- requirements
Module: mux_rr_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width per channel.
REQ-002 SHALL have parameter N, default 8: channel count; legal range 2..16.
REQ-003 SHALL derive localparam SEL_W = clog2(N) and SHALL NOT expose it as a port parameter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
REQ-007 sel  input  SEL_W  channel index used when mode=0.
REQ-008 in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  N  per-channel valid.
REQ-010 in_ready  output  N  per-channel ready, combinational.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_ch  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  registered output valid.
REQ-014 out_ready  input  1  downstream ready.
REQ-015 out_par  output  1  registered even parity of out_data; present only under the macro in REQ-035.

Function
REQ-016 load_en SHALL equal (!out_valid || out_ready).
REQ-017 mode=0: chosen SHALL equal sel; if sel >= N, no channel SHALL be chosen.
REQ-018 mode=1: chosen SHALL be the first i with in_valid[i]=1, searching cyclically from ptr upward and wrapping N-1 -> 0.
REQ-019 in_ready[i] SHALL be 1 iff load_en=1 and i equals chosen; all other bits SHALL be 0.
REQ-020 Transfer SHALL occur when in_valid[chosen] && in_ready[chosen]; on transfer, out_data <= that channel's word, out_ch <= chosen, and out_valid <= 1, with latency exactly 1 cycle.
REQ-021 When load_en=1 and no transfer occurs, out_valid SHALL become 0 and out_data/out_ch SHALL hold.
REQ-022 When load_en=0, out_data, out_ch and out_valid SHALL hold unchanged.
REQ-023 On a mode=1 transfer, ptr SHALL become (chosen+1) mod N; wrap N-1 -> 0 is required.
REQ-024 ptr SHALL hold on mode=0 transfers and whenever no transfer occurs.
REQ-025 A mode or sel change SHALL take effect combinationally in the same cycle; ptr is retained across mode changes.
REQ-026 Throughput SHALL be one word per cycle while out_ready=1.
REQ-027 An output transfer and a new input transfer in the same cycle SHALL both complete with no bubble.
REQ-028 No data SHALL be lost or duplicated; each transferred word SHALL appear exactly once on the output handshake.

Reset
REQ-029 rst_n=0 SHALL immediately clear out_valid, out_data, out_ch, ptr and out_par to 0, without waiting for clk.
REQ-030 A word held at reset SHALL be discarded.
REQ-031 in_ready SHALL be all-ones-capable immediately after reset, since out_valid=0 forces load_en=1.
REQ-032 Release of rst_n SHALL be honoured on the next rising clk edge with no extra latency.

Configuration
REQ-033 The macro MUX_RR_PIPE_PARITY_EN SHALL control the parity feature.
REQ-034 Without MUX_RR_PIPE_PARITY_EN, port out_par and its register SHALL be absent; all other behaviour is unchanged.
REQ-035 With MUX_RR_PIPE_PARITY_EN defined, out_par SHALL be registered alongside out_data and equal XOR of the loaded word.

Structure
REQ-036 The shared package mux_pkg SHALL hold the mode encodings MODE_FIXED=0 and MODE_RR=1 and the default constants WIDTH_DEF=16 and N_DEF=8.
REQ-037 The cyclic first-valid search SHALL be the sub-module rr_pick (inputs: req[N], ptr; outputs: gnt_idx, gnt_any).
REQ-038 The datapath SHALL be a single output register stage; no other storage is permitted.

Verification
REQ-039 Reset mid-stream: out_valid=1 holding 0xBEEF, pulse rst_n low between edges -> out_valid=0, out_data=0 immediately; ptr=0 after release.
REQ-040 Fixed select: mode=0, sel=5, in_data ch5=0x1234, in_valid=8'hFF, out_ready=1 -> next cycle out_data=0x1234, out_ch=5; in_ready=8'h20.
REQ-041 Round-robin: mode=1, all valid, out_ready=1 for 10 cycles -> out_ch sequence 0,1,...,7,0,1.
REQ-042 RR skip and wrap: ptr=6, in_valid=8'b0000_0101 -> grants ch0 then ch2; ptr ends at 3.
REQ-043 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, outputs hold; out_ready=1 -> new word loads the same cycle.
REQ-044 Out-of-range select: N=6, mode=0, sel=7 -> in_ready=0; out_valid drops after drain. With MUX_RR_PIPE_PARITY_EN, word 0x0007 gives out_par=1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the mux_rr_pipe block.
//   mode_e      : selection mode encodings (fixed select / round-robin)
//   WIDTH_DEF   : default per-channel data width
//   N_DEF       : default channel count
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int WIDTH_DEF = 16;
  localparam int N_DEF     = 8;

endpackage

// File: rtl/mux_rr_pipe_rr_pick.sv
// rr_pick: cyclic first-set search over a request vector.
// Ports:
//   req     [N]     request bits
//   ptr     [SEL_W] index the search starts from (must be < N)
//   gnt_idx [SEL_W] first index i >= ptr (cyclically, wrapping N-1 -> 0) with req[i]=1
//   gnt_any         1 when any request bit is set
module rr_pick #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int w_idx;

  // Walk from the farthest candidate back to ptr so the closest hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (req[w_idx]) begin
        gnt_idx = SEL_W'(w_idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe: N-channel multiplexer with fixed or round-robin selection and a
// single registered output stage with valid/ready handshakes.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   mode               0 = fixed select via sel, 1 = round-robin
//   sel                channel index used in fixed mode (>= N selects nothing)
//   in_data/in_valid   flattened channel words, channel i at [i*WIDTH +: WIDTH]
//   in_ready           per-channel ready (combinational)
//   out_ready          downstream ready
//   out_data/out_ch    registered word and the channel that supplied it
//   out_valid          registered output valid
//   out_par            registered even parity of out_data (only with MUX_RR_PIPE_PARITY_EN)
// Build option: define MUX_RR_PIPE_PARITY_EN to add the out_par port and register.
module mux_rr_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [$clog2(N)-1:0]  sel,
  input  logic [N*WIDTH-1:0]    in_data,
  input  logic [N-1:0]          in_valid,
  output logic [N-1:0]          in_ready,
  input  logic                  out_ready,
`ifdef MUX_RR_PIPE_PARITY_EN
  output logic                  out_par,
`endif
  output logic [WIDTH-1:0]      out_data,
  output logic [$clog2(N)-1:0]  out_ch,
  output logic                  out_valid
);

  localparam int SEL_W = $clog2(N);

  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_out_valid;

  logic             w_load_en;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_rr_any;
  logic [SEL_W-1:0] w_pick;
  logic             w_pick_ok;
  logic [N-1:0]     w_gnt;
  logic [WIDTH-1:0] w_word;
  logic             w_xfer;
  logic [SEL_W-1:0] w_ptr_next;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt_idx (w_rr_idx),
    .gnt_any (w_rr_any)
  );

  // The output stage can accept a word when empty or draining this cycle.
  assign w_load_en = !r_out_valid || out_ready;

  always_comb begin
    if (mode == MODE_RR) begin
      w_pick    = w_rr_idx;
      w_pick_ok = w_rr_any;
    end else begin
      w_pick    = sel;
      // Non-power-of-two N leaves sel codes that address no channel.
      w_pick_ok = ({1'b0, sel} < (SEL_W + 1)'(N));
    end
  end

  always_comb begin
    w_gnt  = '0;
    w_word = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick_ok && (w_pick == SEL_W'(i))) begin
        w_gnt[i] = 1'b1;
        w_word   = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready   = w_load_en ? w_gnt : '0;
  assign w_xfer     = w_load_en && |(w_gnt & in_valid);
  assign w_ptr_next = (w_pick == SEL_W'(N - 1)) ? '0 : w_pick + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_data  <= w_word;
        r_out_ch    <= w_pick;
        r_out_valid <= 1'b1;
        if (mode == MODE_RR) r_ptr <= w_ptr_next;
      end else if (w_load_en) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

`ifdef MUX_RR_PIPE_PARITY_EN
  logic r_out_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_par <= 1'b0;
    end else if (w_xfer) begin
      r_out_par <= ^w_word;
    end
  end

  assign out_par = r_out_par;
`endif

endmodule
